// File: rtl/snake_pkg.sv
// Shared types and constants for the snake image generator and its LCD cell painter.
// Object codes, RGB565 palette, panel opcodes and the painter FSM encoding.
package snake_pkg;

  typedef enum logic [2:0] {
    BLANK  = 3'd0,
    BODY   = 3'd1,
    HEAD   = 3'd2,
    APPLE  = 3'd3,
    BORDER = 3'd4
  } obj_t;

  localparam logic [15:0] COL_BLANK  = 16'h0000;
  localparam logic [15:0] COL_BODY   = 16'h07E0;
  localparam logic [15:0] COL_HEAD   = 16'h03E0;
  localparam logic [15:0] COL_APPLE  = 16'hF800;
  localparam logic [15:0] COL_BORDER = 16'hFFFF;

  localparam logic [7:0] LCD_CASET = 8'h2A;
  localparam logic [7:0] LCD_PASET = 8'h2B;
  localparam logic [7:0] LCD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_C,
    ST_CASET_D,
    ST_PASET_C,
    ST_PASET_D,
    ST_RAMWR_C,
    ST_PIXEL,
    ST_DONE
  } state_t;

  // Unknown codes (5..7) paint as empty floor.
  function automatic logic [15:0] obj_colour(input logic [2:0] code);
    case (code)
      BODY:    return COL_BODY;
      HEAD:    return COL_HEAD;
      APPLE:   return COL_APPLE;
      BORDER:  return COL_BORDER;
      default: return COL_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/cell_draw_tx_if.sv
// Cell-update request/ack from the generator plus the 8080-style panel write bus.
interface cell_draw_tx_if;
  logic       diff;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       cmd_done;
  logic       busy;
  logic       lcd_csx;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic [7:0] lcd_d;

  modport master (
    output diff, x, y, obj_code,
    input  cmd_done, busy, lcd_csx, lcd_dcx, lcd_wrx, lcd_d
  );

  modport slave (
    input  diff, x, y, obj_code,
    output cmd_done, busy, lcd_csx, lcd_dcx, lcd_wrx, lcd_d
  );
endinterface

// File: rtl/cell_draw_tx_byte_writer.sv
// One panel write strobe per go: wrx low WR_LO_CYC then high WR_HI_CYC cycles, d/dcx held.
// byte_done is combinational in the last high cycle so the next go can chain with no gap.
module lcd_byte_writer #(
  parameter int WR_LO_CYC = 1,
  parameter int WR_HI_CYC = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       go,
  input  logic [7:0] byte_dat,
  input  logic       byte_dcx,
  output logic       wrx,
  output logic       dcx,
  output logic [7:0] d,
  output logic       byte_done
);
  logic       active;
  logic       lo;
  logic [7:0] cnt;

  assign byte_done = active && !lo && (cnt == 8'(WR_HI_CYC - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      active <= 1'b0;
      lo     <= 1'b0;
      cnt    <= 8'd0;
      wrx    <= 1'b1;
      dcx    <= 1'b1;
      d      <= 8'h00;
    end else if (go) begin
      active <= 1'b1;
      lo     <= 1'b1;
      cnt    <= 8'd0;
      wrx    <= 1'b0;
      dcx    <= byte_dcx;
      d      <= byte_dat;
    end else if (active) begin
      if (lo) begin
        if (cnt == 8'(WR_LO_CYC - 1)) begin
          lo  <= 1'b0;
          cnt <= 8'd0;
          wrx <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else if (byte_done) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/cell_draw_tx.sv
// Paints one grid cell per accepted diff: CASET, PASET, RAMWR, CELL_PX^2 pixels, then cmd_done.
// First wrx fall 1 cycle after diff; diff is dropped (not queued) whenever the FSM is not idle.
module cell_draw_tx
  import snake_pkg::*;
#(
  parameter int CELL_PX   = 20,
  parameter int WR_LO_CYC = 1,
  parameter int WR_HI_CYC = 1
) (
  input logic           clk,
  input logic           nrst,
  cell_draw_tx_if.slave bus
);
  localparam logic [8:0] PIX_LAST = 9'(CELL_PX * CELL_PX - 1);
  localparam logic [8:0] EDGE_M1  = 9'(CELL_PX - 1);

  state_t     state, state_n;
  logic [3:0] x_q, y_q;
  logic [2:0] obj_q;
  logic [1:0] idx;
  logic [8:0] pix_cnt;
  logic       phase;
  logic       done_wait;

  logic       go, tx_dcx, byte_done;
  logic [7:0] tx_dat;
  logic [8:0] xs, xe, ys, ye;
  logic [15:0] colour;

  function automatic logic [7:0] coord_byte(input logic [8:0] s, input logic [8:0] e,
                                            input logic [1:0] sel);
    case (sel)
      2'd0:    return {7'd0, s[8]};
      2'd1:    return s[7:0];
      2'd2:    return {7'd0, e[8]};
      default: return e[7:0];
    endcase
  endfunction

  assign xs     = 9'(x_q) * 9'(CELL_PX);
  assign xe     = xs + EDGE_M1;
  assign ys     = 9'(y_q) * 9'(CELL_PX);
  assign ye     = ys + EDGE_M1;
  assign colour = obj_colour(obj_q);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    go      = 1'b0;
    tx_dat  = 8'h00;
    tx_dcx  = 1'b1;
    case (state)
      ST_IDLE: if (bus.diff) begin
        if (bus.y >= 4'd12) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_CASET_C;
          go      = 1'b1;
          tx_dat  = LCD_CASET;
          tx_dcx  = 1'b0;
        end
      end
      ST_CASET_C: if (byte_done) begin
        state_n = ST_CASET_D;
        go      = 1'b1;
        tx_dat  = coord_byte(xs, xe, 2'd0);
      end
      ST_CASET_D: if (byte_done) begin
        go = 1'b1;
        if (idx == 2'd3) begin
          state_n = ST_PASET_C;
          tx_dat  = LCD_PASET;
          tx_dcx  = 1'b0;
        end else begin
          tx_dat = coord_byte(xs, xe, idx + 2'd1);
        end
      end
      ST_PASET_C: if (byte_done) begin
        state_n = ST_PASET_D;
        go      = 1'b1;
        tx_dat  = coord_byte(ys, ye, 2'd0);
      end
      ST_PASET_D: if (byte_done) begin
        go = 1'b1;
        if (idx == 2'd3) begin
          state_n = ST_RAMWR_C;
          tx_dat  = LCD_RAMWR;
          tx_dcx  = 1'b0;
        end else begin
          tx_dat = coord_byte(ys, ye, idx + 2'd1);
        end
      end
      ST_RAMWR_C: if (byte_done) begin
        state_n = ST_PIXEL;
        go      = 1'b1;
        tx_dat  = colour[15:8];
      end
      ST_PIXEL: if (byte_done) begin
        if (!phase) begin
          go     = 1'b1;
          tx_dat = colour[7:0];
        end else if (pix_cnt != PIX_LAST) begin
          go     = 1'b1;
          tx_dat = colour[15:8];
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: if (!done_wait) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // done_wait holds DONE one extra cycle after a real transfer so csx is seen high before cmd_done.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      obj_q     <= 3'd0;
      idx       <= 2'd0;
      pix_cnt   <= 9'd0;
      phase     <= 1'b0;
      done_wait <= 1'b0;
    end else begin
      done_wait <= (state == ST_PIXEL);
      if (state == ST_IDLE) begin
        idx <= 2'd0;
        if (bus.diff) begin
          x_q   <= bus.x;
          y_q   <= bus.y;
          obj_q <= bus.obj_code;
        end
      end
      if ((state == ST_CASET_D || state == ST_PASET_D) && byte_done)
        idx <= idx + 2'd1;
      if (state == ST_RAMWR_C) begin
        phase   <= 1'b0;
        pix_cnt <= 9'd0;
      end else if (state == ST_PIXEL && byte_done) begin
        phase <= ~phase;
        if (phase) pix_cnt <= pix_cnt + 9'd1;
      end
    end
  end

  always_comb begin
    bus.busy     = (state != ST_IDLE);
    bus.cmd_done = (state == ST_DONE) && !done_wait;
    bus.lcd_csx  = !(state inside {ST_CASET_C, ST_CASET_D, ST_PASET_C,
                                   ST_PASET_D, ST_RAMWR_C, ST_PIXEL});
  end

  lcd_byte_writer #(
    .WR_LO_CYC (WR_LO_CYC),
    .WR_HI_CYC (WR_HI_CYC)
  ) u_writer (
    .clk       (clk),
    .nrst      (nrst),
    .go        (go),
    .byte_dat  (tx_dat),
    .byte_dcx  (tx_dcx),
    .wrx       (bus.lcd_wrx),
    .dcx       (bus.lcd_dcx),
    .d         (bus.lcd_d),
    .byte_done (byte_done)
  );
endmodule

// File: tb/tb_cell_draw_tx.sv
// Directed bench for cell_draw_tx: table of cells with hand-computed window bytes and colours.
module tb_cell_draw_tx;
  logic tb_clk;
  logic nrst;

  cell_draw_tx_if bus ();

  cell_draw_tx dut (
    .clk  (tb_clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [2:0]  obj;
    logic [31:0] ca;
    logic [31:0] pa;
    logic [15:0] col;
  } vec_t;

  vec_t vecs[5];
  int   n_pass, n_total;

  logic [8:0] cap[$];
  int first_low, csx_fall, done_at, done_cnt, csx_bad, falls;
  logic busy1, busy_after;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // Called at a negedge; pulses diff and samples every following negedge (sample k = cycle k).
  task automatic run_cell(input logic [3:0] cx, input logic [3:0] cy, input logic [2:0] co,
                          input int inject_at);
    logic wrx_prev;
    cap.delete();
    first_low = -1; csx_fall = -1; done_at = -1; done_cnt = 0; csx_bad = 0; falls = 0;
    busy1 = 1'b0; busy_after = 1'b1;
    bus.x = cx; bus.y = cy; bus.obj_code = co; bus.diff = 1'b1;
    wrx_prev = bus.lcd_wrx;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge tb_clk);
      if (k == 1) busy1 = bus.busy;
      if (!bus.lcd_wrx && wrx_prev) begin
        falls++;
        if (first_low < 0) first_low = k;
      end
      if (!bus.lcd_csx && csx_fall < 0) csx_fall = k;
      if (bus.lcd_wrx && !wrx_prev) cap.push_back({bus.lcd_dcx, bus.lcd_d});
      if (!bus.lcd_wrx && bus.lcd_csx) csx_bad++;
      if (bus.cmd_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (done_at > 0 && k == done_at + 1) busy_after = bus.busy;
      wrx_prev = bus.lcd_wrx;
      if (k == inject_at) begin
        bus.diff = 1'b1; bus.x = ~cx; bus.y = 4'd0; bus.obj_code = 3'd0;
      end else begin
        bus.diff = 1'b0;
      end
      if (done_at > 0 && k >= done_at + 3) break;
    end
    bus.diff = 1'b0;
  endtask

  task automatic check_cell(input vec_t v, input int inject_at);
    logic [8:0] exp_b;
    int got, bad;
    run_cell(v.x, v.y, v.obj, inject_at);
    check("byte_count", cap.size(), 811);
    check("wrx_falls", falls, 811);
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      exp_b = {1'b0, 8'h2A};
      else if (i < 5)  exp_b = {1'b1, v.ca[31-8*(i-1) -: 8]};
      else if (i == 5) exp_b = {1'b0, 8'h2B};
      else if (i < 10) exp_b = {1'b1, v.pa[31-8*(i-6) -: 8]};
      else             exp_b = {1'b0, 8'h2C};
      got = (i < cap.size()) ? int'(cap[i]) : -1;
      check($sformatf("hdr_byte%0d", i), got, int'(exp_b));
    end
    got = (cap.size() > 11) ? int'(cap[11]) : -1;
    check("pix_first", got, int'({1'b1, v.col[15:8]}));
    bad = 0;
    for (int i = 11; i < cap.size(); i++) begin
      exp_b = ((i - 11) % 2 == 0) ? {1'b1, v.col[15:8]} : {1'b1, v.col[7:0]};
      if (cap[i] != exp_b) bad++;
    end
    check("pix_bad", bad, 0);
    check("first_wrx_low", first_low, 1);
    check("csx_fall", csx_fall, 1);
    check("csx_during_wr", csx_bad, 0);
    check("done_latency", done_at, 1624);
    check("done_count", done_cnt, 1);
    check("busy_cycle1", int'(busy1), 1);
    check("busy_after_done", int'(busy_after), 0);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    vecs[0] = '{4'd0,  4'd0,  3'd4, 32'h0000_0013, 32'h0000_0013, 16'hFFFF};
    vecs[1] = '{4'd15, 4'd11, 3'd2, 32'h012C_013F, 32'h00DC_00EF, 16'h03E0};
    vecs[2] = '{4'd3,  4'd5,  3'd7, 32'h003C_004F, 32'h0064_0077, 16'h0000};
    vecs[3] = '{4'd12, 4'd6,  3'd1, 32'h00F0_0103, 32'h0078_008B, 16'h07E0};
    vecs[4] = '{4'd8,  4'd3,  3'd3, 32'h00A0_00B3, 32'h003C_004F, 16'hF800};

    nrst = 1'b0;
    bus.diff = 1'b0; bus.x = 4'd0; bus.y = 4'd0; bus.obj_code = 3'd0;
    repeat (2) @(negedge tb_clk);
    check("rst_csx", int'(bus.lcd_csx), 1);
    check("rst_dcx", int'(bus.lcd_dcx), 1);
    check("rst_wrx", int'(bus.lcd_wrx), 1);
    check("rst_d", int'(bus.lcd_d), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.cmd_done), 0);
    nrst = 1'b1;
    @(negedge tb_clk);

    // Reset asserted mid-pixel-stream while wrx is low (odd cycle).
    bus.x = 4'd2; bus.y = 4'd2; bus.obj_code = 3'd3; bus.diff = 1'b1;
    @(negedge tb_clk);
    bus.diff = 1'b0;
    repeat (500) @(negedge tb_clk);
    check("mid_wrx_low", int'(bus.lcd_wrx), 0);
    check("mid_busy", int'(bus.busy), 1);
    nrst = 1'b0;
    #1;
    check("mrst_csx", int'(bus.lcd_csx), 1);
    check("mrst_dcx", int'(bus.lcd_dcx), 1);
    check("mrst_wrx", int'(bus.lcd_wrx), 1);
    check("mrst_d", int'(bus.lcd_d), 0);
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_done", int'(bus.cmd_done), 0);
    @(negedge tb_clk);
    nrst = 1'b1;
    @(negedge tb_clk);

    for (int i = 0; i < 5; i++) check_cell(vecs[i], 0);

    // Row off the grid: no bus activity, cmd_done the next cycle.
    run_cell(4'd3, 4'd12, 3'd4, 0);
    check("y12_bytes", cap.size(), 0);
    check("y12_falls", falls, 0);
    check("y12_csx", csx_fall, -1);
    check("y12_done", done_at, 1);
    check("y12_count", done_cnt, 1);

    // diff during the transfer must not disturb it.
    check_cell(vecs[1], 100);
    // diff in the cmd_done cycle is dropped.
    check_cell(vecs[3], 1624);
    // The very next request is still served normally.
    run_cell(4'd1, 4'd1, 3'd0, 0);
    check("post_done", done_at, 1624);
    check("post_bytes", cap.size(), 811);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
